// File: rtl/dual_edge_event_counter.sv
// ---------------------------------------------------------------------------
// dual_edge_event_counter
//
// Event/timebase counter fed by two prescalers on opposite clock edges.
// The rising-edge prescaler counts 0..RISE_MOD-1 and the falling-edge
// prescaler counts 0..FALL_MOD-1; each wrap is one event. A CNT_W-bit main
// counter on the rising edge accumulates both kinds of event (a coincident
// pair adds 2). The counter can wrap or saturate, and it has a sticky
// overflow flag and a registered compare-match pulse.
//
// Falling-edge wraps cross into the posedge domain through a toggle flop.
// The posedge side keeps a registered copy of that toggle, and the XOR of
// the two marks a pending fall event. A fall wrap at negedge k is therefore
// counted at posedge k+1.
//
// Optional build macro:
//   DUAL_EDGE_CAPTURE_EN - adds cap_i / cap_val_o. This is a snapshot
//                          register that loads the pre-update count.
//
// Reset rst is synchronous and active-low. The posedge registers sample it
// at posedge and the negedge registers sample it at negedge.
// ---------------------------------------------------------------------------
module dual_edge_event_counter #(
    parameter int CNT_W    = 5,
    parameter int PS_W     = 4,
    parameter int RISE_MOD = 11,
    parameter int FALL_MOD = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             sat_mode_i,
    input  logic [CNT_W-1:0] cmp_val_i,
`ifdef DUAL_EDGE_CAPTURE_EN
    input  logic             cap_i,
    output logic [CNT_W-1:0] cap_val_o,
`endif
    output logic [CNT_W-1:0] count_o,
    output logic [PS_W-1:0]  rise_cnt_o,
    output logic [PS_W-1:0]  fall_cnt_o,
    output logic             ovf_o,
    output logic             match_o
);

    localparam logic [PS_W-1:0]  RISE_LAST = PS_W'(RISE_MOD - 1);
    localparam logic [PS_W-1:0]  FALL_LAST = PS_W'(FALL_MOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // ---------------- negedge domain ----------------
    logic [PS_W-1:0] fall_cnt_q, fall_cnt_d;
    logic            fall_tgl_q, fall_tgl_d;

    // ---------------- posedge domain ----------------
    logic [PS_W-1:0]  rise_cnt_q, rise_cnt_d;
    logic             fall_tgl_cap_q, fall_tgl_cap_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             match_q, match_d;

    logic             rise_evt;
    logic             fall_evt;
    logic [1:0]       inc;
    logic [CNT_W:0]   sum;
    logic             hit_up;
    logic             hit_wrap;

    // Fall prescaler next state: clear wins over enable; the toggle flips once per wrap.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        fall_cnt_d = fall_cnt_q;
        fall_tgl_d = fall_tgl_q;
        if (clr_i) begin
            fall_cnt_d = '0;
        end else if (en_i) begin
            if (fall_cnt_q == FALL_LAST) begin
                fall_cnt_d = '0;
                fall_tgl_d = ~fall_tgl_q;
            end else begin
                fall_cnt_d = fall_cnt_q + PS_W'(1);
            end
        end
    end

    // Fall prescaler and wrap toggle registers, clocked on the falling edge.
    always_ff @(negedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (!rst) begin
            fall_cnt_q <= '0;
            fall_tgl_q <= 1'b0;
        end else begin
            fall_cnt_q <= fall_cnt_d;
            fall_tgl_q <= fall_tgl_d;
        end
    end

    // Event detection and the widened increment / compare arithmetic.
    always_comb begin
        rise_evt = en_i && (rise_cnt_q == RISE_LAST);
        fall_evt = fall_tgl_q ^ fall_tgl_cap_q;
        inc      = {1'b0, rise_evt} + {1'b0, fall_evt};
        sum      = {1'b0, count_q} + {{(CNT_W-1){1'b0}}, inc};
        // Target crossed without wrapping: old < cmp <= old + inc.
        hit_up   = (count_q < cmp_val_i) && ({1'b0, cmp_val_i} <= sum);
        // Target crossed past the top of the range in wrap mode.
        hit_wrap = !sat_mode_i && sum[CNT_W] && (cmp_val_i <= sum[CNT_W-1:0]);
    end

    // Posedge next state: clear discards this cycle's events and resyncs the toggle copy.
    always_comb begin
        rise_cnt_d     = rise_cnt_q;
        count_d        = count_q;
        ovf_d          = ovf_q;
        match_d        = 1'b0;
        // The copy always follows the toggle, so a pending fall event is consumed
        // at this edge. When clr is high, that event is dropped rather than counted.
        fall_tgl_cap_d = fall_tgl_q;
        if (clr_i) begin
            rise_cnt_d = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
        end else begin
            if (en_i) begin
                rise_cnt_d = rise_evt ? '0 : rise_cnt_q + PS_W'(1);
            end
            if (sat_mode_i && sum[CNT_W]) begin
                count_d = CNT_MAX;
            end else begin
                count_d = sum[CNT_W-1:0];
            end
            ovf_d   = ovf_q | sum[CNT_W];
            match_d = hit_up | hit_wrap;
        end
    end

    // Posedge state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rise_cnt_q     <= '0;
            fall_tgl_cap_q <= 1'b0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            match_q        <= 1'b0;
        end else begin
            rise_cnt_q     <= rise_cnt_d;
            fall_tgl_cap_q <= fall_tgl_cap_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            match_q        <= match_d;
        end
    end

`ifdef DUAL_EDGE_CAPTURE_EN
    logic [CNT_W-1:0] cap_val_q, cap_val_d;

    // Snapshot next state: a capture request beats clr in the same cycle.
    always_comb begin
        cap_val_d = cap_val_q;
        if (cap_i) begin
            cap_val_d = count_q;
        end else if (clr_i) begin
            cap_val_d = '0;
        end
    end

    // Snapshot register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_val_q <= '0;
        end else begin
            cap_val_q <= cap_val_d;
        end
    end

    assign cap_val_o = cap_val_q;
`endif

    assign count_o    = count_q;
    assign rise_cnt_o = rise_cnt_q;
    assign fall_cnt_o = fall_cnt_q;
    assign ovf_o      = ovf_q;
    assign match_o    = match_q;

endmodule

// File: tb/tb_dual_edge_event_counter.sv
// ---------------------------------------------------------------------------
// tb_dual_edge_event_counter
//
// Inputs change 1 time unit after a negedge. All outputs are compared
// 1 time unit after the following negedge. By then both the posedge
// update and the negedge update have settled.
//
// The reference model tracks the prescalers and the counter as integers:
// - Each prescaler is a modular count.
// - A fall wrap is a pending flag that the next posedge consumes.
// - The counter is plain integer addition, then clamped or reduced modulo 2**CNT_W.
//
// Set DUAL_EDGE_CAPTURE_EN to exercise the capture register as well.
// ---------------------------------------------------------------------------
module tb_dual_edge_event_counter;

    localparam int CNT_W    = 5;
    localparam int PS_W     = 4;
    localparam int RISE_MOD = 11;
    localparam int FALL_MOD = 6;
    localparam int MAXV     = (1 << CNT_W) - 1;
    localparam int ALL_W    = 2*CNT_W + 2*PS_W + 2;

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             en       = 1'b0;
    logic             clr      = 1'b0;
    logic             sat_mode = 1'b0;
    logic [CNT_W-1:0] cmp_val  = '0;
    logic [CNT_W-1:0] count;
    logic [PS_W-1:0]  rise_cnt;
    logic [PS_W-1:0]  fall_cnt;
    logic             ovf;
    logic             match;
    logic [CNT_W-1:0] cap_val_w;

`ifdef DUAL_EDGE_CAPTURE_EN
    logic             cap = 1'b0;
    logic [CNT_W-1:0] cap_val;
    assign cap_val_w = cap_val;
`else
    assign cap_val_w = '0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    int m_rise  = 0;
    int m_fall  = 0;
    int m_count = 0;
    int m_cap   = 0;
    bit m_pend  = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_match = 1'b0;

    dual_edge_event_counter #(
        .CNT_W   (CNT_W),
        .PS_W    (PS_W),
        .RISE_MOD(RISE_MOD),
        .FALL_MOD(FALL_MOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en),
        .clr_i     (clr),
        .sat_mode_i(sat_mode),
        .cmp_val_i (cmp_val),
`ifdef DUAL_EDGE_CAPTURE_EN
        .cap_i     (cap),
        .cap_val_o (cap_val),
`endif
        .count_o   (count),
        .rise_cnt_o(rise_cnt),
        .fall_cnt_o(fall_cnt),
        .ovf_o     (ovf),
        .match_o   (match)
    );

    always #5 clk = ~clk;

    // Behavioural reference model. One process serves both edges.
    always @(posedge clk or negedge clk) begin : ref_model
        int inc;
        int sum;
        int cmp;
        if (clk) begin
            if (!rst) begin
                m_rise = 0; m_count = 0; m_ovf = 0; m_match = 0; m_pend = 0; m_cap = 0;
            end else begin
`ifdef DUAL_EDGE_CAPTURE_EN
                if (cap)      m_cap = m_count;
                else if (clr) m_cap = 0;
`endif
                if (clr) begin
                    m_rise = 0; m_count = 0; m_ovf = 0; m_match = 0; m_pend = 0;
                end else begin
                    inc = ((en && m_rise == RISE_MOD - 1) ? 1 : 0) + (m_pend ? 1 : 0);
                    m_pend = 0;
                    if (en) m_rise = (m_rise + 1) % RISE_MOD;
                    sum = m_count + inc;
                    cmp = int'(cmp_val);
                    m_match = (inc > 0) &&
                              ((m_count < cmp && cmp <= sum) ||
                               (!sat_mode && sum > MAXV && cmp <= sum - (MAXV + 1)));
                    if (sum > MAXV) m_ovf = 1;
                    if (sat_mode) m_count = (sum > MAXV) ? MAXV : sum;
                    else          m_count = sum % (MAXV + 1);
                end
            end
        end else begin
            if (!rst) begin
                m_fall = 0; m_pend = 0;
            end else if (clr) begin
                m_fall = 0;
            end else if (en) begin
                m_fall = (m_fall + 1) % FALL_MOD;
                if (m_fall == 0) m_pend = 1;
            end
        end
    end

    function automatic logic [ALL_W-1:0] dut_all();
        return {count, rise_cnt, fall_cnt, ovf, match, cap_val_w};
    endfunction

    function automatic logic [ALL_W-1:0] exp_all();
        return {CNT_W'(m_count), PS_W'(m_rise), PS_W'(m_fall), m_ovf, m_match, CNT_W'(m_cap)};
    endfunction

    // Increment the model expects at the next posedge (no clr, no reset).
    function automatic int nxt_inc();
        return ((en && m_rise == RISE_MOD - 1) ? 1 : 0) + (m_pend ? 1 : 0);
    endfunction

    // Advance one full clock: posedge, then negedge, then settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Advance until a model condition holds or the budget runs out.
    task automatic seek(input int kind, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (kind)
                0:       found = (m_count + nxt_inc() > MAXV);
                1:       found = (m_count == MAXV - 1 && nxt_inc() == 2);
                2:       found = (m_count == MAXV && nxt_inc() == 1);
                default: found = (m_count == 9);
            endcase
            if (found) break;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; clr = 1'b0; sat_mode = 1'b0; cmp_val = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if ({count, rise_cnt, fall_cnt, ovf, match} !== '0) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d got=%h required=0", i,
                         {count, rise_cnt, fall_cnt, ovf, match});
            end
        end
    endtask

    task automatic test_basic_run();
        int exp_c;
        rst = 1'b1; en = 1'b1; sat_mode = 1'b0; cmp_val = CNT_W'(13);
        for (int p = 1; p <= 70; p++) begin
            step();
            n_chk++;
            if (dut_all() !== exp_all()) begin
                n_fail++;
                $display("FAIL basic_model p=%0d got=%h required=%h", p, dut_all(), exp_all());
            end
            case (p)
                7:       exp_c = 1;
                11:      exp_c = 2;
                54:      exp_c = 12;
                55:      exp_c = 14;
                66:      exp_c = 16;
                67:      exp_c = 17;
                default: exp_c = -1;
            endcase
            if (exp_c >= 0) begin
                n_chk++;
                if (count !== CNT_W'(exp_c)) begin
                    n_fail++;
                    $display("FAIL basic_count p=%0d got=%0d required=%0d", p, count, exp_c);
                end
            end
            if (p >= 54 && p <= 56) begin
                n_chk++;
                if (match !== (p == 55)) begin
                    n_fail++;
                    $display("FAIL basic_match p=%0d got=%0b required=%0b", p, match, p == 55);
                end
            end
        end
    endtask

    task automatic test_wrap();
        bit found;
        int e;
        // Wrap mode: the first overflow from a clean start.
        clr = 1'b1; step(); clr = 1'b0;
        seek(0, 2500, found);
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL wrap_first_ovf got=not_reached required=reached");
        end else begin
            e = (m_count + nxt_inc()) % (MAXV + 1);
            step();
            if (count !== CNT_W'(e) || ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_first_ovf got cnt=%0d ovf=%0b required cnt=%0d ovf=1", count, ovf, e);
            end
        end
        // Wrap mode: 30 + 2 lands on 0.
        seek(1, 2500, found);
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL wrap_30p2 got=not_reached required=reached");
        end else begin
            step();
            if (count !== '0 || ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_30p2 got cnt=%0d ovf=%0b required cnt=0 ovf=1", count, ovf);
            end
        end
        // Compare value 0 pulses on 31 -> 0.
        cmp_val = '0;
        seek(2, 2500, found);
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL wrap_match0 got=not_reached required=reached");
        end else begin
            step();
            if (match !== 1'b1 || count !== '0) begin
                n_fail++;
                $display("FAIL wrap_match0 got match=%0b cnt=%0d required match=1 cnt=0", match, count);
            end
        end
        // Saturate mode: clamp at max and hold with no further matches.
        sat_mode = 1'b1; cmp_val = CNT_W'(MAXV);
        clr = 1'b1; step(); clr = 1'b0;
        seek(0, 2500, found);
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL sat_clamp got=not_reached required=reached");
        end else begin
            step();
            if (count !== CNT_W'(MAXV) || ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_clamp got cnt=%0d ovf=%0b required cnt=%0d ovf=1", count, ovf, MAXV);
            end
        end
        for (int i = 0; i < 40; i++) begin
            step();
            n_chk++;
            if (count !== CNT_W'(MAXV) || match !== 1'b0 || dut_all() !== exp_all()) begin
                n_fail++;
                $display("FAIL sat_hold i=%0d got cnt=%0d match=%0b required cnt=%0d match=0", i, count, match, MAXV);
            end
        end
        sat_mode = 1'b0;
    endtask

    task automatic test_clr();
        rst = 1'b0; en = 1'b1; clr = 1'b0; cmp_val = CNT_W'(13);
        step();
        rst = 1'b1;
        for (int p = 1; p <= 60; p++) begin
            clr = (p == 40);
            step();
            n_chk++;
            if (dut_all() !== exp_all()) begin
                n_fail++;
                $display("FAIL clr_model p=%0d got=%h required=%h", p, dut_all(), exp_all());
            end
            if (p == 40) begin
                n_chk++;
                if ({count, rise_cnt, fall_cnt, ovf} !== '0) begin
                    n_fail++;
                    $display("FAIL clr_zero got=%h required=0", {count, rise_cnt, fall_cnt, ovf});
                end
            end
            if (p == 46 || p == 47) begin
                n_chk++;
                if (count !== CNT_W'(p - 46)) begin
                    n_fail++;
                    $display("FAIL clr_restart p=%0d got=%0d required=%0d", p, count, p - 46);
                end
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_reset_enable();
        int s_count;
        int s_rise;
        int s_fall;
        bit found;
        for (int i = 0; i < 17; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_chk++;
        if ({count, rise_cnt, fall_cnt, ovf, match} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset got=%h required=0", {count, rise_cnt, fall_cnt, ovf, match});
        end
        for (int i = 0; i < 10; i++) step();
        en = 1'b0;
        step();   // a fall wrap from the last enabled negedge may still land here
        s_count = m_count; s_rise = m_rise; s_fall = m_fall;
        for (int i = 0; i < 19; i++) begin
            step();
            n_chk++;
            if (count !== CNT_W'(s_count) || rise_cnt !== PS_W'(s_rise) ||
                fall_cnt !== PS_W'(s_fall) || dut_all() !== exp_all()) begin
                n_fail++;
                $display("FAIL enable_freeze i=%0d got cnt=%0d rise=%0d fall=%0d required cnt=%0d rise=%0d fall=%0d",
                         i, count, rise_cnt, fall_cnt, s_count, s_rise, s_fall);
            end
        end
        en = 1'b1;
`ifdef DUAL_EDGE_CAPTURE_EN
        rst = 1'b0; step(); rst = 1'b1;
        seek(3, 500, found);
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL capture9 got=not_reached required=reached");
        end else begin
            cap = 1'b1; step(); cap = 1'b0;
            if (cap_val !== CNT_W'(9)) begin
                n_fail++;
                $display("FAIL capture9 got=%0d required=9", cap_val);
            end
        end
`else
        found = 1'b0;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            clr     = ($urandom_range(0, 59) == 0);
            rst     = ($urandom_range(0, 149) != 0);
            cmp_val = CNT_W'($urandom_range(0, MAXV));
            if ($urandom_range(0, 99) == 0) sat_mode = ~sat_mode;
`ifdef DUAL_EDGE_CAPTURE_EN
            cap     = ($urandom_range(0, 19) == 0);
`endif
            step();
            n_chk++;
            if (dut_all() !== exp_all()) begin
                n_fail++;
                $display("FAIL random_model i=%0d got=%h required=%h", i, dut_all(), exp_all());
            end
        end
        rst = 1'b1; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_wrap();
        test_clr();
        test_reset_enable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
